// File: rtl/maxpool_pkg.sv
// rtl/maxpool_pkg.sv - state encoding and counter width helpers shared by the max-pool sequencer
package maxpool_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  // Bits needed to count 0..n-1; a single-value counter still gets one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int col_w(input int w);
    return cnt_w(w);
  endfunction

  function automatic int row_w(input int h);
    return cnt_w(h);
  endfunction

  function automatic int ch_w(input int ch);
    return cnt_w(ch);
  endfunction

  function automatic int stats_w(input int w, input int h);
    return $clog2((w / 2) * (h / 2) + 1);
  endfunction

endpackage

// File: rtl/maxpool_pos_cnt.sv
// rtl/maxpool_pos_cnt.sv - cascaded col/row/ch position counter with parity and terminal flags
module maxpool_pos_cnt
  import maxpool_pkg::*;
#(
  parameter int W  = 30,
  parameter int H  = 30,
  parameter int CH = 4
) (
  input  logic iCLK,
  input  logic iRSTn,
  input  logic pos_clr_i,
  input  logic col_inc_i,
  input  logic ch_clr_i,
  input  logic ch_inc_i,
  output logic col_odd_o,
  output logic row_odd_o,
  output logic col_last_o,
  output logic row_last_o,
  output logic ch_last_o
);

  localparam int CW  = col_w(W);
  localparam int RW  = row_w(H);
  localparam int HW  = ch_w(CH);
  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);
  localparam logic [HW-1:0] CH_MAX  = HW'(CH - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [HW-1:0] ch_q, ch_d;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      col_q <= '0;
      row_q <= '0;
      ch_q  <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      ch_q  <= ch_d;
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    ch_d  = ch_q;
    if (pos_clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (col_inc_i) begin
      if (col_last_o) begin
        col_d = '0;
        row_d = row_last_o ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (ch_clr_i) begin
      ch_d = '0;
    end else if (ch_inc_i && !ch_last_o) begin
      ch_d = ch_q + HW'(1);
    end
  end

  assign col_odd_o  = col_q[0];
  assign row_odd_o  = row_q[0];
  assign col_last_o = (col_q == COL_MAX);
  assign row_last_o = (row_q == ROW_MAX);
  assign ch_last_o  = (ch_q == CH_MAX);

endmodule

// File: rtl/maxpool_seq.sv
// rtl/maxpool_seq.sv - 2x2 binary max-pool sequencer; define MAXPOOL_SEQ_STATS_EN to add the oONES counter
module maxpool_seq
  import maxpool_pkg::*;
#(
  parameter int W  = 30,
  parameter int H  = 30,
  parameter int CH = 4
) (
  input  logic iCLK,
  input  logic iRSTn,
  input  logic iSTART,
  input  logic iDATA,
  input  logic iVALID,
  output logic oREADY,
  output logic oEN,
  output logic oCLR,
  input  logic iPOOL,
  output logic oDATA,
  output logic oVALID,
  input  logic iREADY,
  output logic oBUSY,
  output logic oDONE
`ifdef MAXPOOL_SEQ_STATS_EN
  ,
  output logic [stats_w(W, H)-1:0] oONES
`endif
);

  state_e state_q, state_d;
  logic   pend_q, pend_d;
  logic   ovalid_q, ovalid_d;
  logic   odata_q, odata_d;
  logic   col_odd, row_odd, col_last, row_last, ch_last;
  logic   cap, pool_hit, drain_exit;

  // Pixel data goes straight to the line buffer one level up.
  logic unused_data;
  assign unused_data = iDATA;

  assign cap        = pend_q && (!ovalid_q || iREADY);
  assign pool_hit   = oEN && row_odd && col_odd;
  assign drain_exit = (state_q == DRAIN) && !pend_q && !ovalid_q;

  maxpool_pos_cnt #(.W(W), .H(H), .CH(CH)) u_pos (
    .iCLK      (iCLK),
    .iRSTn     (iRSTn),
    .pos_clr_i (state_q == CLEAR),
    .col_inc_i (oEN),
    .ch_clr_i  ((state_q == IDLE) && iSTART),
    .ch_inc_i  (drain_exit),
    .col_odd_o (col_odd),
    .row_odd_o (row_odd),
    .col_last_o(col_last),
    .row_last_o(row_last),
    .ch_last_o (ch_last)
  );

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (iSTART) state_d = CLEAR;
      CLEAR:   state_d = STREAM;
      STREAM:  if (oEN && row_last && col_last) state_d = DRAIN;
      DRAIN:   if (drain_exit) state_d = ch_last ? IDLE : CLEAR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oREADY = (state_q == STREAM) && !(ovalid_q && !iREADY) && !(pend_q && ovalid_q && !iREADY);
    oEN    = iVALID && oREADY;
    oCLR   = (state_q == CLEAR);
    oBUSY  = (state_q != IDLE);
    oDONE  = (state_q == DRAIN) && ch_last && !pend_q && ovalid_q && iREADY;
  end

  // iPOOL is sampled one cycle after the odd/odd shift, once the window holds it.
  always_comb begin
    pend_d   = pend_q;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    if (pool_hit) begin
      pend_d = 1'b1;
    end else if (cap) begin
      pend_d = 1'b0;
    end
    if (cap) begin
      ovalid_d = 1'b1;
      odata_d  = iPOOL;
    end else if (iREADY) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      pend_q   <= 1'b0;
      ovalid_q <= 1'b0;
      odata_q  <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
    end
  end

  assign oVALID = ovalid_q;
  assign oDATA  = odata_q;

`ifdef MAXPOOL_SEQ_STATS_EN
  localparam int SW = stats_w(W, H);
  localparam logic [SW-1:0] ONES_MAX = '1;

  logic [SW-1:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if (state_q == CLEAR) begin
      ones_d = '0;
    end else if (cap && iPOOL && (ones_q != ONES_MAX)) begin
      ones_d = ones_q + SW'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign oONES = ones_q;
`endif

endmodule

// File: doc/maxpool_seq.md
# maxpool_seq

Sequencer for the binary 2×2 max-pool line buffer. It accepts a raster stream of 1-bit feature-map pixels over a valid/ready handshake and drives the buffer's shift-enable and clear strobes. It decodes row/column position so that only pooled results at odd/odd window positions are forwarded downstream, and it repeats this for CH channels per start command. It sits between the binarized convolution output stage and the next layer's input FIFO.

## Interface
- W, 30: feature-map row width in pixels; even, ≥2; equals the line buffer length.
- H, 30: rows per channel; even, ≥2.
- CH, 4: channels per start command; ≥1.
- iCLK  in  1  clock.
- iRSTn  in  1  reset, asynchronous, active-low.
- iSTART  in  1  start-frame pulse; sampled only in IDLE.
- iDATA  in  1  input pixel.
- iVALID  in  1  input pixel valid.
- oREADY  out  1  input pixel accepted when iVALID && oREADY.
- oEN  out  1  line-buffer shift enable.
- oCLR  out  1  line-buffer synchronous clear.
- iPOOL  in  1  line-buffer 2×2 OR result; combinational from buffer contents.
- oDATA  out  1  pooled pixel.
- oVALID  out  1  pooled pixel valid.
- iREADY  in  1  downstream ready.
- oBUSY  out  1  high in every state except IDLE.
- oDONE  out  1  one-cycle pulse when the last pooled pixel of the last channel is taken.

## Operation
- All outputs reset to 0. State resets to IDLE. All counters and the pend flag reset to 0.
- States:
  - IDLE: on iSTART, go to CLEAR and zero ch.
  - CLEAR: assert oCLR for one cycle, zero col and row, then go to STREAM.
  - STREAM: accept pixels.
  - DRAIN: after the last pixel of a channel, wait until pend==0 && oVALID==0.
  - From DRAIN: go to CLEAR if ch<CH-1 (increment ch), else go to IDLE and pulse oDONE on the cycle the final oVALID is taken.
- Input handshake:
  - oREADY = (state==STREAM) && !(oVALID && !iREADY) && !(pend && oVALID && !iREADY).
  - oEN = iVALID && oREADY. Each accept advances col.
  - col wraps W-1→0 and increments row.
  - Accepting (row=H-1, col=W-1) moves to DRAIN.
- Pool decode: an accept with row odd and col odd sets pend. At that point the window holds (r-1,c-1), (r-1,c), (r,c-1), (r,c).
- Capture:
  - When pend && (!oVALID || iREADY): load oDATA←iPOOL, set oVALID=1, clear pend.
  - Otherwise pend holds. iPOOL stays stable because oEN is 0 while stalled.
- Output: oVALID clears on iREADY unless reloaded in the same cycle. oDATA holds while oVALID && !iREADY.
- Pooled outputs per channel: (W/2)·(H/2), in raster order of pooled coordinates.
- iSTART outside IDLE is ignored. iVALID outside STREAM is ignored (oREADY=0).
- iRSTn low mid-operation aborts the frame. The buffer is cleared through the CLEAR state on the next start.

## Timing
- Latency: an accept at cycle t of an odd/odd pixel gives oVALID=1 at cycle t+2 when unstalled. (Shift at end of t; iPOOL valid in t+1; registered at end of t+1.)
- Sustained throughput: 1 pixel/cycle with iREADY held high.
- CLEAR costs 1 cycle per channel. DRAIN takes ≥1 cycle.
- Simultaneous pend-load and iREADY drain: the new value replaces the old one with no bubble.
- oDONE coincides with the cycle in which the final oVALID && iREADY occurs.

## Configuration
- MAXPOOL_SEQ_STATS_EN:
  - Defined: add output oONES [$clog2((W/2)*(H/2)+1)-1:0]. It counts pooled 1s of the current channel, clears in CLEAR, and saturates at its maximum.
  - Undefined: the port and its counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package maxpool_pkg holds:
  - the state enum (IDLE, CLEAR, STREAM, DRAIN);
  - the width functions for the col, row, ch and stats counters.
- Sub-module maxpool_pos_cnt: a cascaded col/row/ch counter with enable, clear and terminal-count flags, instantiated once.
- The line buffer itself is instantiated beside this block at the next level up, not inside it.

## Test plan
- W=4, H=4, CH=1, all-ones input, iREADY=1 → 4 oVALID pulses, all oDATA=1, oDONE once, 16 oEN cycles and 1 oCLR.
- W=4, H=4, single 1 at (row 2, col 1) → pooled outputs 0,0,1,0; first oVALID 2 cycles after the accept of (1,1).
- iREADY held low for 5 cycles when the first pooled result is pending → oREADY=0, oEN=0 and oDATA stable throughout; resume with no lost or duplicated output.
- CH=3, random data → 3 oCLR pulses, 12 outputs matching a reference OR-pool, oBUSY high from start to oDONE.
- Assert iRSTn low mid-row of channel 1 → all outputs 0 immediately; a new iSTART produces a clean first-channel result.
- With MAXPOOL_SEQ_STATS_EN, checkerboard input → oONES=4 at end of channel; cleared to 0 in the next CLEAR.
